animation_sequencer: RTL
========================

ANIMATION_SEQUENCER -- requirements
Module: animation_sequencer

Interface
REQ-001 SHALL have parameter NUM_ANI, default 34, meaning the number of animations, valid indices 0..NUM_ANI-1 (range 2..64).
REQ-002 SHALL have parameter LOOPS, default 4, meaning the number of complete frame loops before an auto-advance (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: global enable; when low, all state holds.
REQ-006 SHALL have port tick, input, 1 bit: frame-rate strobe, one clk wide.
REQ-007 SHALL have ports btn_next and btn_prev, input, 1 bit each: debounced single-cycle select pulses.
REQ-008 SHALL have port hold, input, 1 bit: level; freezes the frame counter.
REQ-009 SHALL have port limit, input, 6 bits: last frame index of the current animation, from the combinational limit lookup.
REQ-010 SHALL have port animation, output, 6 bits: current animation index; drives the limit lookup and the decoder.
REQ-011 SHALL have port frame, output, 6 bits: current frame index, 0..limit.
REQ-012 SHALL have ports frame_stb and loop_done, output, 1 bit each: frame_stb is a one-cycle pulse on each frame advance; loop_done is a one-cycle pulse when frame wraps limit->0.

Function
REQ-013 SHALL implement the FSM states ST_RUN, ST_HOLD and ST_SWITCH, all registered.
REQ-014 ST_RUN: on tick, frame SHALL advance by 1; if frame >= limit, frame SHALL go to 0 and loop_done SHALL pulse; frame_stb SHALL pulse in both cases, one cycle after tick.
REQ-015 ST_RUN: when hold=1, the FSM SHALL go to ST_HOLD; ST_HOLD SHALL ignore tick and return to ST_RUN when hold=0; frame SHALL be unchanged.
REQ-016 On btn_next XOR btn_prev in ST_RUN or ST_HOLD, animation SHALL update the next cycle, frame SHALL go to 0, loop count SHALL go to 0, and the FSM SHALL enter ST_SWITCH.
REQ-017 btn_next at NUM_ANI-1 SHALL wrap animation to 0; btn_prev at 0 SHALL wrap animation to NUM_ANI-1.
REQ-018 When btn_next and btn_prev are asserted in the same cycle, both SHALL be ignored.
REQ-019 ST_SWITCH SHALL last exactly one cycle so that limit settles, SHALL ignore tick and buttons, SHALL not pulse frame_stb, and SHALL then go to ST_RUN (or ST_HOLD if hold=1).
REQ-020 If frame > limit in ST_RUN (limit dropped), frame SHALL clear to 0 on the next cycle without a loop_done pulse.
REQ-021 A button pulse SHALL have priority over tick in the same cycle; the tick is dropped.
REQ-022 When ena=0, all registers SHALL hold and pulse outputs SHALL be 0.
REQ-023 All arithmetic SHALL be 6-bit unsigned; limit=0 SHALL give frame constantly 0 with loop_done on every tick.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously set state to ST_SWITCH, animation to 0, frame to 0, loop count to 0, and frame_stb and loop_done to 0.
REQ-025 After reset release, the first cycle SHALL be ST_SWITCH and ST_RUN SHALL follow.
REQ-026 Reset mid-frame or mid-switch SHALL discard all progress; no pulse SHALL be emitted.

Configuration
REQ-027 Macro AUTO_CYCLE_EN defined: a 4-bit loop counter SHALL count loop_done pulses; at LOOPS it SHALL behave exactly as btn_next (wrap, ST_SWITCH, counter cleared); ST_HOLD SHALL freeze it.
REQ-028 Macro AUTO_CYCLE_EN undefined: there SHALL be no loop counter, animation SHALL change only via buttons, and loop_done SHALL still function.

Verification
REQ-029 Reset, limit=9, 12 ticks -> frame 0..9,0,1,2; loop_done exactly once, one cycle after the 10th tick.
REQ-030 animation=33 (NUM_ANI=34), btn_next -> animation=0, frame=0, one ST_SWITCH cycle; btn_prev at 0 -> animation=33.
REQ-031 btn_next and btn_prev in the same cycle -> animation, frame and state unchanged.
REQ-032 hold=1 at frame=3, 5 ticks -> frame stays 3, no frame_stb; hold=0, tick -> frame=4.
REQ-033 AUTO_CYCLE_EN, LOOPS=4, limit=1, animation=7 -> after the 8th tick animation=8; without the macro -> animation stays 7.
REQ-034 frame=10, limit changes to 5 -> frame=0 the next cycle, no loop_done; rst_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/animation_sequencer.sv
// Animation/frame sequencer: steps frames on tick, selects animations via buttons, optional auto-advance (AUTO_CYCLE_EN).
// Latency: frame/animation/pulses registered, visible one cycle after the causing input.
// Backpressure: none; ena=0 freezes all state and masks pulses, hold freezes the frame counter.
module animation_sequencer #(
    parameter int NUM_ANI = 34,
    parameter int LOOPS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tick,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       hold,
    input  logic [5:0] limit,
    output logic [5:0] animation,
    output logic [5:0] frame,
    output logic       frame_stb,
    output logic       loop_done
);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SWITCH} state_t;

    localparam logic [5:0] LAST_ANI = 6'(NUM_ANI - 1);

    state_t     state_q, state_d;
    logic [5:0] anim_d, frame_d;
    logic [5:0] anim_inc, anim_dec;
    logic       stb_q, stb_d, done_q, done_d;
    logic       sel_next, sel_prev, sel_any;

`ifdef AUTO_CYCLE_EN
    localparam logic [3:0] LOOPS_C = 4'(LOOPS);
    logic [3:0] loops_q, loops_d;
`endif

    // Simultaneous next+prev cancel each other out.
    assign sel_next = btn_next & ~btn_prev;
    assign sel_prev = btn_prev & ~btn_next;
    assign sel_any  = sel_next | sel_prev;
    assign anim_inc = (animation == LAST_ANI) ? 6'd0 : animation + 6'd1;
    assign anim_dec = (animation == 6'd0) ? LAST_ANI : animation - 6'd1;

    always_comb begin
        state_d = state_q;
        anim_d  = animation;
        frame_d = frame;
        stb_d   = 1'b0;
        done_d  = 1'b0;
`ifdef AUTO_CYCLE_EN
        loops_d = loops_q;
`endif
        case (state_q)
            // One settling cycle so the external limit lookup follows the new animation.
            ST_SWITCH: state_d = hold ? ST_HOLD : ST_RUN;
            default: begin
                if (sel_any) begin
                    anim_d  = sel_next ? anim_inc : anim_dec;
                    frame_d = 6'd0;
                    state_d = ST_SWITCH;
`ifdef AUTO_CYCLE_EN
                    loops_d = 4'd0;
`endif
                end else if (state_q == ST_HOLD) begin
                    if (!hold) state_d = ST_RUN;
                end else if (hold) begin
                    state_d = ST_HOLD;
                end else if (frame > limit) begin
                    // Limit shrank under us: restart silently.
                    frame_d = 6'd0;
                end else if (tick) begin
                    stb_d = 1'b1;
                    if (frame >= limit) begin
                        frame_d = 6'd0;
                        done_d  = 1'b1;
`ifdef AUTO_CYCLE_EN
                        if (loops_q + 4'd1 == LOOPS_C) begin
                            anim_d  = anim_inc;
                            loops_d = 4'd0;
                            state_d = ST_SWITCH;
                        end else begin
                            loops_d = loops_q + 4'd1;
                        end
`endif
                    end else begin
                        frame_d = frame + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SWITCH;
            animation <= 6'd0;
            frame     <= 6'd0;
            stb_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef AUTO_CYCLE_EN
            loops_q   <= 4'd0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            animation <= anim_d;
            frame     <= frame_d;
            stb_q     <= stb_d;
            done_q    <= done_d;
`ifdef AUTO_CYCLE_EN
            loops_q   <= loops_d;
`endif
        end else begin
            stb_q  <= 1'b0;
            done_q <= 1'b0;
        end
    end

    assign frame_stb = stb_q & ena;
    assign loop_done = done_q & ena;

endmodule
